axis_flit_injector: RTL and testbench
=====================================

Name: axis_flit_injector

Overview:
- Single-clock NoC injection bridge: accepts AXI-Stream beats from the user side and emits credit-flow-controlled router flits (data, dest, is_tail, send) toward a router local input port.
- Each TDATA_WIDTH beat is serialized into SERIALIZATION_FACTOR flits.
- Packet destination is locked per packet.
- Successor to the registered AXIS pass-through stub: adds serialization, credit tracking, wormhole-safe dest locking and error flagging.

Parameters:
- TDATA_WIDTH, 32, AXIS data width.
- TID_WIDTH, 2, AXIS tid width.
- TDEST_WIDTH, 4, AXIS tdest width.
- SERIALIZATION_FACTOR, 4, flits per beat; must divide TDATA_WIDTH; legal values ≥1.
- FLIT_WIDTH, TDATA_WIDTH/SERIALIZATION_FACTOR, flit payload width (derived).
- DEST_WIDTH, TDEST_WIDTH+TID_WIDTH, flit dest width (derived).
- NUM_CREDITS, 4, downstream buffer depth in flits; ≥1.
- CREDIT_WIDTH, $clog2(NUM_CREDITS+1), credit counter width (derived).

Ports:
- clk_noc  input  1  sole clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- axis_in_tvalid  input  1  beat valid.
- axis_in_tready  output  1  beat ready.
- axis_in_tdata  input  TDATA_WIDTH  beat payload.
- axis_in_tlast  input  1  last beat of packet.
- axis_in_tid  input  TID_WIDTH  stream id.
- axis_in_tdest  input  TDEST_WIDTH  destination router.
- data_out  output  FLIT_WIDTH  flit payload.
- dest_out  output  DEST_WIDTH  {tdest,tid} of current packet.
- is_tail_out  output  1  last flit of packet.
- send_out  output  1  flit valid this cycle; one credit consumed.
- credit_in  input  1  one downstream buffer slot freed.
- credits_avail  output  CREDIT_WIDTH  current credit count.
- busy  output  1  beat held or packet open.
- err_credit_overflow  output  1  sticky: credit_in received while count == NUM_CREDITS.

Behaviour:
- Reset (async assert, sync-safe deassert by the surrounding reset synchronizer):
  - send_out=0, is_tail_out=0, data_out=0, dest_out=0.
  - credits_avail=NUM_CREDITS, busy=0, err_credit_overflow=0.
  - axis_in_tready=0 while rst_n low; FSM=IDLE; packet-open flag=0.
  - Reset mid-packet discards held beat and partial packet with no tail flit; credits return to NUM_CREDITS.
- All flit outputs are registered. send_out is high for exactly one cycle per flit.
- Credits:
  - cnt_next = cnt - issue + credit_in.
  - issue is allowed only when registered cnt != 0; there is no combinational bypass of credit_in.
  - Simultaneous issue and credit_in at cnt==1 leaves cnt at 1.
  - credit_in at cnt==NUM_CREDITS with no issue: cnt saturates; err_credit_overflow set until reset.
- FSM IDLE:
  - axis_in_tready=1.
  - On handshake: latch beat into shift register, flit index=0, FSM→SEND.
  - If cnt!=0 in the handshake cycle, flit 0 (tdata[FLIT_WIDTH-1:0]) is issued on the same edge. Latency: handshake in cycle t → send_out=1 in cycle t+1.
- FSM SEND:
  - Flits issue LSB slice first, index 0..SF-1, one per cycle while cnt!=0; stalls hold all state.
  - axis_in_tready=1 only in the cycle the final flit (index SF-1) issues, and the next beat is accepted on that edge.
  - Back-to-back beats therefore sustain 1 flit/cycle with no bubble.
  - After the final flit with no new beat, FSM→IDLE.
- Dest locking:
  - On the first beat of a packet (packet-open=0), {tdest,tid} is latched into dest_out and packet-open is set.
  - Later beats' tdest/tid are ignored until the tlast beat completes.
  - packet-open clears when the tail flit issues.
- is_tail_out=1 only on flit SF-1 of a beat accepted with tlast=1.
- SF=1: each beat is one flit, issued in the handshake cycle if cnt!=0. FSM stays in IDLE-equivalent, tready=(cnt!=0)||held-empty.
- busy = (FSM!=IDLE) || packet-open.

Test Plan:
- Reset check: SF=4, NUM_CREDITS=4 → credits_avail=4, send_out=0, tready=1 after release, err=0.
- Single-beat packet, tdata=0xDDCCBBAA, tid=1, tdest=5, tlast=1, credit_in tied 0 → data_out AA,BB,CC,DD on cycles t+1..t+4; dest_out=0x15; is_tail only on DD; credits_avail 4→0.
- Credit stall: NUM_CREDITS=2, same beat, credit_in pulsed at cycle t+6 and t+8 → flits AA,BB issue immediately, CC in cycle after first credit, DD in cycle after second credit; tready low throughout.
- Back-to-back 3-beat packet, credit_in=1 every cycle after the first flit, tdest changed on beats 2–3 → 12 consecutive send_out cycles; dest_out constant = first beat's value; only flit 12 has is_tail.
- Overflow: idle at cnt=4, pulse credit_in → credits_avail stays 4, err_credit_overflow=1 and stays set.
- Reset mid-packet after flit 2 → outputs and counters return to reset values; the next packet's dest is latched fresh.

Source files
------------

// File: rtl/axis_flit_injector.sv
// AXI-Stream to credit-flow-controlled NoC flit injector.
// Serializes each beat into SERIALIZATION_FACTOR flits (LSB slice first),
// locks {tdest,tid} for the whole packet and tracks downstream credits.
module axis_flit_injector #(
  parameter int unsigned TDATA_WIDTH          = 32,
  parameter int unsigned TID_WIDTH            = 2,
  parameter int unsigned TDEST_WIDTH          = 4,
  parameter int unsigned SERIALIZATION_FACTOR = 4,
  parameter int unsigned NUM_CREDITS          = 4
) (
  input  logic                                      clk_noc,
  input  logic                                      rst_n,
  input  logic                                      axis_in_tvalid,
  output logic                                      axis_in_tready,
  input  logic [TDATA_WIDTH-1:0]                    axis_in_tdata,
  input  logic                                      axis_in_tlast,
  input  logic [TID_WIDTH-1:0]                      axis_in_tid,
  input  logic [TDEST_WIDTH-1:0]                    axis_in_tdest,
  output logic [TDATA_WIDTH/SERIALIZATION_FACTOR-1:0] data_out,
  output logic [TDEST_WIDTH+TID_WIDTH-1:0]          dest_out,
  output logic                                      is_tail_out,
  output logic                                      send_out,
  input  logic                                      credit_in,
  output logic [$clog2(NUM_CREDITS+1)-1:0]          credits_avail,
  output logic                                      busy,
  output logic                                      err_credit_overflow
);

  localparam int unsigned SF           = SERIALIZATION_FACTOR;
  localparam int unsigned FLIT_WIDTH   = TDATA_WIDTH / SF;
  localparam int unsigned DEST_WIDTH   = TDEST_WIDTH + TID_WIDTH;
  localparam int unsigned CREDIT_WIDTH = $clog2(NUM_CREDITS + 1);
  localparam int unsigned IDX_W        = (SF > 1) ? $clog2(SF) : 1;
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(SF - 1);
  localparam logic [CREDIT_WIDTH-1:0] MAX_CRED = CREDIT_WIDTH'(NUM_CREDITS);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t                  state_q, state_n;
  logic [IDX_W-1:0]        idx_q, idx_n;
  logic [TDATA_WIDTH-1:0]  sreg_q, sreg_n;
  logic                    last_q, last_n;
  logic                    pkt_open_q, pkt_open_n;
  logic [DEST_WIDTH-1:0]   dest_q, dest_n;
  logic [CREDIT_WIDTH-1:0] cnt_q, cnt_n;
  logic                    err_q, err_n;
  logic                    tready_q, tready_n;
  logic                    busy_q, busy_n;
  logic                    send_q, tail_q;
  logic [FLIT_WIDTH-1:0]   data_q;

  logic                    issue, tail, hs, cnt_ok;
  logic [FLIT_WIDTH-1:0]   flit;

  // Next-state: beat acceptance, flit issue, dest locking and credit accounting
  always_comb begin
    state_n    = state_q;
    idx_n      = idx_q;
    sreg_n     = sreg_q;
    last_n     = last_q;
    pkt_open_n = pkt_open_q;
    dest_n     = dest_q;
    err_n      = err_q;
    issue      = 1'b0;
    tail       = 1'b0;
    flit       = sreg_q[FLIT_WIDTH-1:0];
    hs         = axis_in_tvalid & tready_q;
    cnt_ok     = (cnt_q != '0);

    case (state_q)
      S_IDLE: begin
        if (hs) begin
          sreg_n  = axis_in_tdata;
          last_n  = axis_in_tlast;
          idx_n   = '0;
          state_n = S_SEND;
          if (!pkt_open_q) begin
            dest_n     = {axis_in_tdest, axis_in_tid};
            pkt_open_n = 1'b1;
          end
          // Flit 0 leaves on the handshake edge when a credit is available
          if (cnt_ok) begin
            issue  = 1'b1;
            flit   = axis_in_tdata[FLIT_WIDTH-1:0];
            sreg_n = axis_in_tdata >> FLIT_WIDTH;
            if (SF == 1) begin
              tail    = axis_in_tlast;
              state_n = S_IDLE;
              if (axis_in_tlast) pkt_open_n = 1'b0;
            end else begin
              idx_n = IDX_W'(1);
            end
          end
        end
      end
      S_SEND: begin
        if (cnt_ok) begin
          issue  = 1'b1;
          flit   = sreg_q[FLIT_WIDTH-1:0];
          sreg_n = sreg_q >> FLIT_WIDTH;
          if (idx_q == LAST_IDX) begin
            tail  = last_q;
            idx_n = '0;
            if (last_q) pkt_open_n = 1'b0;
            // Next beat is taken on the same edge as the final flit
            if (hs) begin
              sreg_n = axis_in_tdata;
              last_n = axis_in_tlast;
              if (!pkt_open_n) begin
                dest_n     = {axis_in_tdest, axis_in_tid};
                pkt_open_n = 1'b1;
              end
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            idx_n = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Credit counter saturates at NUM_CREDITS; extra returns are flagged
    if (credit_in && !issue && (cnt_q == MAX_CRED)) begin
      cnt_n = cnt_q;
      err_n = 1'b1;
    end else begin
      cnt_n = cnt_q - CREDIT_WIDTH'(issue) + CREDIT_WIDTH'(credit_in);
    end

    tready_n = (state_n == S_IDLE) || ((idx_n == LAST_IDX) && (cnt_n != '0));
    busy_n   = (state_n != S_IDLE) || pkt_open_n;
  end

  // State and registered outputs
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      sreg_q     <= '0;
      last_q     <= 1'b0;
      pkt_open_q <= 1'b0;
      dest_q     <= '0;
      cnt_q      <= MAX_CRED;
      err_q      <= 1'b0;
      tready_q   <= 1'b0;
      busy_q     <= 1'b0;
      send_q     <= 1'b0;
      tail_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_n;
      idx_q      <= idx_n;
      sreg_q     <= sreg_n;
      last_q     <= last_n;
      pkt_open_q <= pkt_open_n;
      dest_q     <= dest_n;
      cnt_q      <= cnt_n;
      err_q      <= err_n;
      tready_q   <= tready_n;
      busy_q     <= busy_n;
      send_q     <= issue;
      tail_q     <= issue & tail;
      if (issue) data_q <= flit;
    end
  end

  assign axis_in_tready      = tready_q;
  assign data_out            = data_q;
  assign dest_out            = dest_q;
  assign is_tail_out         = tail_q;
  assign send_out            = send_q;
  assign credits_avail       = cnt_q;
  assign busy                = busy_q;
  assign err_credit_overflow = err_q;

endmodule

// File: tb/tb_axis_flit_injector.sv
// Directed bench for axis_flit_injector (default parameters: 32b, SF=4, 4 credits).
module tb_axis_flit_injector;

  logic        clk_noc;
  logic        rst_n;
  logic        axis_in_tvalid;
  logic        axis_in_tready;
  logic [31:0] axis_in_tdata;
  logic        axis_in_tlast;
  logic [1:0]  axis_in_tid;
  logic [3:0]  axis_in_tdest;
  logic [7:0]  data_out;
  logic [5:0]  dest_out;
  logic        is_tail_out;
  logic        send_out;
  logic        credit_in;
  logic [2:0]  credits_avail;
  logic        busy;
  logic        err_credit_overflow;

  int n_checks = 0;
  int n_errors = 0;

  axis_flit_injector u_dut (
    .clk_noc             (clk_noc),
    .rst_n               (rst_n),
    .axis_in_tvalid      (axis_in_tvalid),
    .axis_in_tready      (axis_in_tready),
    .axis_in_tdata       (axis_in_tdata),
    .axis_in_tlast       (axis_in_tlast),
    .axis_in_tid         (axis_in_tid),
    .axis_in_tdest       (axis_in_tdest),
    .data_out            (data_out),
    .dest_out            (dest_out),
    .is_tail_out         (is_tail_out),
    .send_out            (send_out),
    .credit_in           (credit_in),
    .credits_avail       (credits_avail),
    .busy                (busy),
    .err_credit_overflow (err_credit_overflow)
  );

  initial clk_noc = 1'b0;
  always #5 clk_noc = ~clk_noc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_noc);
    #1;
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic [1:0] id,
                            input logic [3:0] dst, input logic last);
    axis_in_tvalid = 1'b1;
    axis_in_tdata  = d;
    axis_in_tid    = id;
    axis_in_tdest  = dst;
    axis_in_tlast  = last;
  endtask

  logic [31:0] b2b_data [3];
  logic [3:0]  b2b_dest [3];
  logic [7:0]  exp_bytes [4];
  int          bi;
  logic        hs;

  initial begin
    rst_n          = 1'b0;
    axis_in_tvalid = 1'b0;
    axis_in_tdata  = '0;
    axis_in_tlast  = 1'b0;
    axis_in_tid    = '0;
    axis_in_tdest  = '0;
    credit_in      = 1'b0;
    exp_bytes[0] = 8'hAA; exp_bytes[1] = 8'hBB; exp_bytes[2] = 8'hCC; exp_bytes[3] = 8'hDD;

    // Reset state
    repeat (3) @(posedge clk_noc);
    #1;
    check("rst_tready", 32'(axis_in_tready), 32'd0);
    check("rst_credits", 32'(credits_avail), 32'd4);
    check("rst_send", 32'(send_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check("rel_tready", 32'(axis_in_tready), 32'd1);
    check("rel_credits", 32'(credits_avail), 32'd4);
    check("rel_err", 32'(err_credit_overflow), 32'd0);

    // Single-beat packet, no credit returns
    drive_beat(32'hDDCCBBAA, 2'd1, 4'd5, 1'b1);
    tick();
    axis_in_tvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("sb_send", 32'(send_out), 32'd1);
      check("sb_data", 32'(data_out), 32'(exp_bytes[i]));
      check("sb_tail", 32'(is_tail_out), 32'(i == 3));
      check("sb_dest", 32'(dest_out), 32'h15);
      check("sb_credits", 32'(credits_avail), 32'(3 - i));
      if (i == 1) check("sb_tready_low", 32'(axis_in_tready), 32'd0);
      if (i < 3) tick();
    end
    tick();
    check("sb_idle_send", 32'(send_out), 32'd0);
    check("sb_idle_busy", 32'(busy), 32'd0);
    check("sb_idle_tready", 32'(axis_in_tready), 32'd1);

    // Credit stall with only two credits available
    credit_in = 1'b1;
    tick();
    tick();
    credit_in = 1'b0;
    check("st_credits2", 32'(credits_avail), 32'd2);
    drive_beat(32'hDDCCBBAA, 2'd1, 4'd5, 1'b1);
    tick();
    axis_in_tvalid = 1'b0;
    check("st_f0", 32'(data_out), 32'hAA);
    tick();
    check("st_f1", 32'(data_out), 32'hBB);
    check("st_f1_cred", 32'(credits_avail), 32'd0);
    tick();
    check("st_stall_send", 32'(send_out), 32'd0);
    tick();
    check("st_stall_send2", 32'(send_out), 32'd0);
    check("st_stall_tready", 32'(axis_in_tready), 32'd0);
    check("st_stall_busy", 32'(busy), 32'd1);
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    check("st_cred_in_send", 32'(send_out), 32'd0);
    check("st_cred_in_cnt", 32'(credits_avail), 32'd1);
    tick();
    check("st_f2_send", 32'(send_out), 32'd1);
    check("st_f2", 32'(data_out), 32'hCC);
    check("st_f2_tail", 32'(is_tail_out), 32'd0);
    tick();
    check("st_stall3_send", 32'(send_out), 32'd0);
    check("st_stall3_tready", 32'(axis_in_tready), 32'd0);
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    tick();
    check("st_f3_send", 32'(send_out), 32'd1);
    check("st_f3", 32'(data_out), 32'hDD);
    check("st_f3_tail", 32'(is_tail_out), 32'd1);
    check("st_f3_busy", 32'(busy), 32'd0);

    // Refill credits to 4
    credit_in = 1'b1;
    repeat (4) tick();
    credit_in = 1'b0;
    check("refill", 32'(credits_avail), 32'd4);

    // Back-to-back 3-beat packet, dest changes ignored after the first beat
    b2b_data[0] = 32'h03020100; b2b_dest[0] = 4'd3;
    b2b_data[1] = 32'h07060504; b2b_dest[1] = 4'd9;
    b2b_data[2] = 32'h0B0A0908; b2b_dest[2] = 4'hA;
    bi = 0;
    drive_beat(b2b_data[0], 2'd2, b2b_dest[0], 1'b0);
    for (int cyc = 0; cyc < 16; cyc++) begin
      hs = axis_in_tvalid && axis_in_tready;
      credit_in = (cyc >= 1) && (cyc <= 11);
      tick();
      if (hs) begin
        bi++;
        if (bi < 3) drive_beat(b2b_data[bi], 2'd0, b2b_dest[bi], bi == 2);
        else axis_in_tvalid = 1'b0;
      end
      check("b2b_send", 32'(send_out), 32'(cyc < 12));
      if (cyc < 12) begin
        check("b2b_data", 32'(data_out), 32'(cyc));
        check("b2b_tail", 32'(is_tail_out), 32'(cyc == 11));
        check("b2b_dest", 32'(dest_out), 32'h0E);
      end
    end
    credit_in = 1'b0;
    check("b2b_beats", 32'(bi), 32'd3);
    check("b2b_credits", 32'(credits_avail), 32'd3);
    check("b2b_busy", 32'(busy), 32'd0);

    // Credit overflow at full count
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    check("ov_full", 32'(credits_avail), 32'd4);
    check("ov_err_pre", 32'(err_credit_overflow), 32'd0);
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    check("ov_sat", 32'(credits_avail), 32'd4);
    check("ov_err", 32'(err_credit_overflow), 32'd1);
    tick();
    tick();
    check("ov_err_sticky", 32'(err_credit_overflow), 32'd1);

    // Reset in the middle of a packet
    drive_beat(32'hDDCCBBAA, 2'd3, 4'd7, 1'b1);
    tick();
    axis_in_tvalid = 1'b0;
    tick();
    check("mr_f1", 32'(data_out), 32'hBB);
    check("mr_dest", 32'(dest_out), 32'h1F);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_send", 32'(send_out), 32'd0);
    check("mr_data", 32'(data_out), 32'd0);
    check("mr_dest0", 32'(dest_out), 32'd0);
    check("mr_tail", 32'(is_tail_out), 32'd0);
    check("mr_credits", 32'(credits_avail), 32'd4);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_err", 32'(err_credit_overflow), 32'd0);
    check("mr_tready", 32'(axis_in_tready), 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    check("mr_post_send", 32'(send_out), 32'd0);
    drive_beat(32'h44332211, 2'd0, 4'd2, 1'b1);
    tick();
    axis_in_tvalid = 1'b0;
    check("np_dest", 32'(dest_out), 32'h08);
    check("np_f0", 32'(data_out), 32'h11);
    check("np_credits", 32'(credits_avail), 32'd3);
    check("np_busy", 32'(busy), 32'd1);
    repeat (3) tick();
    check("np_f3", 32'(data_out), 32'h44);
    check("np_tail", 32'(is_tail_out), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
